// File: rtl/pipe_stage_skid_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_if
//
// One valid/ready channel between two pipeline stages: a control field that
// downstream logic decodes (WB_EN, MEM_R_EN, ...) plus an opaque payload.
//
//   valid  producer -> consumer   entry on ctrl/data is valid this cycle
//   ready  consumer -> producer   consumer accepts this cycle
//   ctrl   producer -> consumer   CTRL_W control bits
//   data   producer -> consumer   DATA_W payload bits
//
// Modports:
//   master : the side that produces entries (drives valid/ctrl/data)
//   slave  : the side that consumes entries (drives ready)
// ---------------------------------------------------------------------------
interface pipe_stage_skid_if #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output ctrl,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  ctrl,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Generic inter-stage register for the ARM core pipeline (IF/ID, ID/EXE,
// EXE/MEM, MEM/WB). Carries a control field and a payload under valid/ready.
//
// With SKID=1 a second (skid) register absorbs one extra entry after the
// consumer stalls, so in_ready is a function of registered state and flush
// only; there is no combinational path from out_ready to in_ready.
// With SKID=0 the stage is a single register and in_ready is combinational:
// it may accept whenever it is empty or the held entry leaves this cycle.
//
// Flush discards every held entry and presents a bubble (control forced to
// zero, payload optionally cleared). The number of valid entries discarded
// is accumulated in a saturating counter.
//
// Parameters:
//   CTRL_W      control width, zeroed on every bubble
//   DATA_W      payload width
//   SKID        1 = two entries with registered ready, 0 = single register
//   CLEAR_DATA  1 = payload also zeroed on flush/reset, 0 = payload retained
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   flush        discard held entries, present a bubble
//   in_ch        upstream channel   (slave: valid/ctrl/data in, ready out)
//   out_ch       downstream channel (master: valid/ctrl/data out, ready in)
//   occupancy    number of held entries (0..2, at most 1 when SKID=0)
//   flush_drops  saturating count of valid entries discarded by flush
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int CTRL_W     = 8,
  parameter int DATA_W     = 128,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  pipe_stage_skid_if.slave         in_ch,
  pipe_stage_skid_if.master        out_ch,
  output logic [1:0]               occupancy,
  output logic [15:0]              flush_drops
);

  // EMPTY: nothing held. ONE: main register (M) full. TWO: M and skid (S)
  // full; only reachable when SKID=1.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t              state_reg,  state_next;
  logic [CTRL_W-1:0]   m_ctrl_reg, m_ctrl_next;
  logic [DATA_W-1:0]   m_data_reg, m_data_next;
  logic [CTRL_W-1:0]   s_ctrl_reg, s_ctrl_next;
  logic [DATA_W-1:0]   s_data_reg, s_data_next;
  logic [15:0]         drops_reg,  drops_next;

  logic                out_valid_int;
  logic                in_ready_int;
  logic                in_fire;
  logic                out_fire;
  logic [1:0]          occ_int;
  logic [1:0]          drop_cnt;
  logic [16:0]         drops_sum;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  assign out_valid_int = (state_reg != ST_EMPTY);

  generate
    if (SKID != 0) begin : g_ready_skid
      // Registered ready: only the state and flush decide, never out_ready.
      assign in_ready_int = (state_reg != ST_TWO) & ~flush & ~rst;
    end else begin : g_ready_comb
      // Single register: room exists if empty or the held entry leaves now.
      assign in_ready_int = (~out_valid_int | out_ch.ready) & ~flush & ~rst;
    end
  endgenerate

  assign in_fire  = in_ch.valid & in_ready_int;
  assign out_fire = out_valid_int & out_ch.ready;

  // -------------------------------------------------------------------------
  // Occupancy and flush drop accounting
  // -------------------------------------------------------------------------
  always_comb begin
    occ_int = 2'd0;
    case (state_reg)
      ST_EMPTY: occ_int = 2'd0;
      ST_ONE:   occ_int = 2'd1;
      ST_TWO:   occ_int = 2'd2;
      default:  occ_int = 2'd0;
    endcase
  end

  // An entry that transfers downstream in the flush cycle was delivered, not
  // dropped, so it is subtracted from the count. out_fire implies occ >= 1.
  assign drop_cnt  = occ_int - {1'b0, out_fire};
  assign drops_sum = {1'b0, drops_reg} + {15'd0, drop_cnt};

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    m_ctrl_next = m_ctrl_reg;
    m_data_next = m_data_reg;
    s_ctrl_next = s_ctrl_reg;
    s_data_next = s_data_reg;
    drops_next  = drops_reg;

    if (flush) begin
      // Flush outranks every handshake event; in_fire is already blocked
      // because in_ready is low while flush is high.
      state_next  = ST_EMPTY;
      m_ctrl_next = '0;
      s_ctrl_next = '0;
      if (CLEAR_DATA != 0) begin
        m_data_next = '0;
        s_data_next = '0;
      end
      drops_next = drops_sum[16] ? 16'hFFFF : drops_sum[15:0];
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            state_next  = ST_ONE;
            m_ctrl_next = in_ch.ctrl;
            m_data_next = in_ch.data;
          end
        end

        ST_ONE: begin
          if (in_fire && out_fire) begin
            // Head leaves and the new entry replaces it in the same cycle.
            m_ctrl_next = in_ch.ctrl;
            m_data_next = in_ch.data;
          end else if (in_fire) begin
            // Consumer stalled: park the newcomer behind the head. With
            // SKID=0 in_ready forbids this case, so the branch is inert.
            if (SKID != 0) begin
              state_next  = ST_TWO;
              s_ctrl_next = in_ch.ctrl;
              s_data_next = in_ch.data;
            end
          end else if (out_fire) begin
            // Payload is kept; only control is zeroed so the bubble is a NOP.
            state_next  = ST_EMPTY;
            m_ctrl_next = '0;
          end
        end

        ST_TWO: begin
          // in_ready is low here, so only the head can move.
          if (out_fire) begin
            state_next  = ST_ONE;
            m_ctrl_next = s_ctrl_reg;
            m_data_next = s_data_reg;
            s_ctrl_next = '0;
          end
        end

        default: begin
          state_next  = ST_EMPTY;
          m_ctrl_next = '0;
          s_ctrl_next = '0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // State registers (asynchronous reset clears held entries; reset-cleared
  // entries are not counted as flush drops)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_EMPTY;
      m_ctrl_reg <= '0;
      m_data_reg <= '0;
      s_ctrl_reg <= '0;
      s_data_reg <= '0;
      drops_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      m_ctrl_reg <= m_ctrl_next;
      m_data_reg <= m_data_next;
      s_ctrl_reg <= s_ctrl_next;
      s_data_reg <= s_data_next;
      drops_reg  <= drops_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs come straight from M. Control is gated by valid as well, so a
  // consumer that ignores out_valid always decodes a NOP on a bubble.
  // -------------------------------------------------------------------------
  assign in_ch.ready  = in_ready_int;
  assign out_ch.valid = out_valid_int;
  assign out_ch.ctrl  = out_valid_int ? m_ctrl_reg : '0;
  assign out_ch.data  = m_data_reg;
  assign occupancy    = occ_int;
  assign flush_drops  = drops_reg;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Two instances: dut1 (SKID=1, CLEAR_DATA=1) and dut0 (SKID=0). Directed
// vector tables cover streaming, back-pressure and flush corner cases; a
// hand-written sequence covers asynchronous reset; a randomized phase is
// checked against a queue-based model of a FIFO of capacity 2 (SKID=1) or
// 1 (SKID=0). Inputs change 1 time unit after the rising edge; outputs are
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;
  localparam int CW = 8;
  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        fl1, fl0;
  logic [1:0]  occ1, occ0;
  logic [15:0] drops1, drops0;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) in1 ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) out1 ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) in0 ();
  pipe_stage_skid_if #(.CTRL_W(CW), .DATA_W(DW)) out0 ();

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLEAR_DATA(1)) dut1 (
    .clk(clk), .rst(rst), .flush(fl1), .in_ch(in1), .out_ch(out1),
    .occupancy(occ1), .flush_drops(drops1)
  );

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLEAR_DATA(1)) dut0 (
    .clk(clk), .rst(rst), .flush(fl0), .in_ch(in0), .out_ch(out0),
    .occupancy(occ0), .flush_drops(drops0)
  );

  typedef struct {
    logic        iv;
    logic        orr;
    logic        fl;
    logic [7:0]  c;
    logic [31:0] d;
    logic        e_ov;
    logic [7:0]  e_c;
    logic [31:0] e_d;
    logic [1:0]  e_occ;
    logic        e_ir;
    logic [15:0] e_drops;
  } vec_t;

  typedef struct {
    logic [7:0]  c;
    logic [31:0] d;
  } ent_t;

  int checks = 0;
  int errors = 0;

  vec_t tbl1[$];
  vec_t tbl0[$];
  ent_t mq[$];

  function automatic vec_t mk(input logic iv, input logic orr, input logic fl,
                              input logic [7:0] c, input logic [31:0] d,
                              input logic e_ov, input logic [7:0] e_c,
                              input logic [31:0] e_d, input logic [1:0] e_occ,
                              input logic e_ir, input logic [15:0] e_drops);
    vec_t v;
    v.iv = iv; v.orr = orr; v.fl = fl; v.c = c; v.d = d;
    v.e_ov = e_ov; v.e_c = e_c; v.e_d = e_d; v.e_occ = e_occ;
    v.e_ir = e_ir; v.e_drops = e_drops;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int k, input logic v, input logic r, input logic f,
                       input logic [7:0] c, input logic [31:0] d);
    if (k == 1) begin
      in1.valid = v; out1.ready = r; fl1 = f; in1.ctrl = c; in1.data = d;
    end else begin
      in0.valid = v; out0.ready = r; fl0 = f; in0.ctrl = c; in0.data = d;
    end
  endtask

  task automatic check_all(input string tag, input int k, input logic eov,
                           input logic [7:0] ec, input logic [31:0] ed,
                           input logic [1:0] eocc, input logic eir,
                           input logic [15:0] edr, input bit chk_data);
    logic        ir, ov;
    logic [7:0]  oc;
    logic [31:0] od;
    logic [1:0]  occ;
    logic [15:0] dr;
    if (k == 1) begin
      ir = in1.ready; ov = out1.valid; oc = out1.ctrl; od = out1.data; occ = occ1; dr = drops1;
    end else begin
      ir = in0.ready; ov = out0.valid; oc = out0.ctrl; od = out0.data; occ = occ0; dr = drops0;
    end
    chk({tag, "_out_valid"}, {31'd0, ov}, {31'd0, eov});
    chk({tag, "_out_ctrl"}, {24'd0, oc}, {24'd0, ec});
    if (chk_data) chk({tag, "_out_data"}, od, ed);
    chk({tag, "_occupancy"}, {30'd0, occ}, {30'd0, eocc});
    chk({tag, "_in_ready"}, {31'd0, ir}, {31'd0, eir});
    chk({tag, "_flush_drops"}, {16'd0, dr}, {16'd0, edr});
  endtask

  // Entered at posedge+1; leaves at the following posedge+1.
  task automatic run_row(input string tag, input int k, input vec_t v);
    drive(k, v.iv, v.orr, v.fl, v.c, v.d);
    #4;
    check_all(tag, k, v.e_ov, v.e_c, v.e_d, v.e_occ, v.e_ir, v.e_drops, 1'b1);
    $display("%s: in_valid=%0b out_ready=%0b flush=%0b data=%0h -> out_valid=%0b out_data=%0h",
             tag, v.iv, v.orr, v.fl, v.d, v.e_ov, v.e_d);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    drive(1, 0, 0, 0, 8'h0, 32'h0);
    drive(0, 0, 0, 0, 8'h0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int   sz;
    int   mdrops;
    logic v, r, f;
    logic [7:0]  c;
    logic [31:0] d;
    logic eir;
    ent_t e;

    // ---------------- vector tables ----------------
    // SKID=1: streaming, back-pressure, flush in TWO, flush with out_fire.
    tbl1.push_back(mk(1,1,0,8'h01,32'h1,  0,8'h00,32'h0, 0,1,0));
    tbl1.push_back(mk(1,1,0,8'h02,32'h2,  1,8'h01,32'h1, 1,1,0));
    tbl1.push_back(mk(1,1,0,8'h03,32'h3,  1,8'h02,32'h2, 1,1,0));
    tbl1.push_back(mk(1,1,0,8'h04,32'h4,  1,8'h03,32'h3, 1,1,0));
    tbl1.push_back(mk(0,1,0,8'h00,32'h0,  1,8'h04,32'h4, 1,1,0));
    tbl1.push_back(mk(0,1,0,8'h00,32'h0,  0,8'h00,32'h4, 0,1,0));
    tbl1.push_back(mk(1,0,0,8'h0A,32'hA,  0,8'h00,32'h4, 0,1,0));
    tbl1.push_back(mk(1,0,0,8'h0B,32'hB,  1,8'h0A,32'hA, 1,1,0));
    tbl1.push_back(mk(1,0,0,8'h0C,32'hC,  1,8'h0A,32'hA, 2,0,0));
    tbl1.push_back(mk(1,1,0,8'h0C,32'hC,  1,8'h0A,32'hA, 2,0,0));
    tbl1.push_back(mk(1,1,0,8'h0C,32'hC,  1,8'h0B,32'hB, 1,1,0));
    tbl1.push_back(mk(0,1,0,8'h00,32'h0,  1,8'h0C,32'hC, 1,1,0));
    tbl1.push_back(mk(0,1,0,8'h00,32'h0,  0,8'h00,32'hC, 0,1,0));
    tbl1.push_back(mk(1,0,0,8'hFF,32'h11, 0,8'h00,32'hC, 0,1,0));
    tbl1.push_back(mk(1,0,0,8'hFF,32'h22, 1,8'hFF,32'h11,1,1,0));
    tbl1.push_back(mk(1,0,1,8'hFF,32'h33, 1,8'hFF,32'h11,2,0,0));
    tbl1.push_back(mk(0,1,0,8'h00,32'h0,  0,8'h00,32'h0, 0,1,2));
    tbl1.push_back(mk(1,1,0,8'h5A,32'h44, 0,8'h00,32'h0, 0,1,2));
    tbl1.push_back(mk(0,1,1,8'h00,32'h0,  1,8'h5A,32'h44,1,0,2));
    tbl1.push_back(mk(0,0,0,8'h00,32'h0,  0,8'h00,32'h0, 0,1,2));
    // SKID=0: continuous input, out_ready 1,0,1,1.
    tbl0.push_back(mk(1,1,0,8'h01,32'h101, 0,8'h00,32'h0,   0,1,0));
    tbl0.push_back(mk(1,0,0,8'h02,32'h102, 1,8'h01,32'h101, 1,0,0));
    tbl0.push_back(mk(1,1,0,8'h02,32'h102, 1,8'h01,32'h101, 1,1,0));
    tbl0.push_back(mk(1,1,0,8'h03,32'h103, 1,8'h02,32'h102, 1,1,0));
    tbl0.push_back(mk(0,1,0,8'h00,32'h0,   1,8'h03,32'h103, 1,1,0));
    tbl0.push_back(mk(0,1,0,8'h00,32'h0,   0,8'h00,32'h103, 0,1,0));

    // ---------------- reset ----------------
    rst = 1'b1;
    drive(1, 0, 0, 0, 8'h0, 32'h0);
    drive(0, 0, 0, 0, 8'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset1", 1, 0, 8'h0, 32'h0, 2'd0, 0, 16'h0, 1'b1);
    check_all("reset0", 0, 0, 8'h0, 32'h0, 2'd0, 0, 16'h0, 1'b1);
    $display("reset: outputs checked while rst high");
    rst = 1'b0;
    #1;
    chk("post_reset1_in_ready", {31'd0, in1.ready}, 32'd1);
    chk("post_reset0_in_ready", {31'd0, in0.ready}, 32'd1);
    @(posedge clk);
    #1;

    // ---------------- SKID=1 table ----------------
    foreach (tbl1[i]) run_row($sformatf("skid1_row%0d", i), 1, tbl1[i]);

    // ---------------- asynchronous reset mid-stream ----------------
    drive(1, 1, 0, 0, 8'h61, 32'h61);
    @(posedge clk); #1;
    drive(1, 1, 0, 0, 8'h62, 32'h62);
    @(posedge clk); #1;
    chk("arst_pre_occupancy", {30'd0, occ1}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check_all("arst_mid", 1, 0, 8'h0, 32'h0, 2'd0, 0, 16'h0, 1'b1);
    $display("async reset asserted between edges with occupancy 2");
    drive(1, 0, 0, 0, 8'h0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 1, 1, 0, 8'h77, 32'h77);
    #4;
    check_all("arst_release", 1, 0, 8'h0, 32'h0, 2'd0, 1, 16'h0, 1'b1);
    @(posedge clk); #1;
    drive(1, 0, 1, 0, 8'h0, 32'h0);
    check_all("arst_first", 1, 1, 8'h77, 32'h77, 2'd1, 1, 16'h0, 1'b1);
    $display("after reset release: first entry 77 visible one cycle later");
    @(posedge clk); #1;

    // ---------------- SKID=0 table ----------------
    foreach (tbl0[i]) run_row($sformatf("skid0_row%0d", i), 0, tbl0[i]);

    // ---------------- randomized phase against FIFO model ----------------
    for (int k = 1; k >= 0; k--) begin
      pulse_reset();
      mq.delete();
      mdrops = 0;
      for (int n = 0; n < 400; n++) begin
        v = (($urandom % 4) != 0);
        r = (($urandom % 3) != 0);
        f = (($urandom % 20) == 0);
        c = 8'($urandom);
        d = $urandom;
        drive(k, v, r, f, c, d);
        #4;
        sz  = mq.size();
        eir = !f && ((k == 1) ? (sz < 2) : (sz == 0 || r));
        check_all($sformatf("rnd%0d_%0d", k, n), k, (sz > 0),
                  (sz > 0) ? mq[0].c : 8'h0, (sz > 0) ? mq[0].d : 32'h0,
                  sz[1:0], eir, mdrops[15:0], (sz > 0));
        $display("rnd skid=%0d cycle %0d: in_valid=%0b out_ready=%0b flush=%0b model_occ=%0d",
                 k, n, v, r, f, sz);
        @(posedge clk);
        if (sz > 0 && r) e = mq.pop_front();
        if (f) begin
          mdrops = mdrops + mq.size();
          if (mdrops > 65535) mdrops = 65535;
          mq.delete();
        end else if (v && eir) begin
          e.c = c;
          e.d = d;
          mq.push_back(e);
        end
        #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register that succeeds the fixed ID/EXE latch. It carries a generic control field and a data payload between any two pipeline stages of the ARM core under a valid/ready handshake. An optional 2-entry skid buffer lets the stage accept back-pressure without a combinational ready path. Flush inserts a bubble, with control bits forced to zero. One instance replaces each hand-written inter-stage register (IF/ID, ID/EXE, EXE/MEM, MEM/WB).

## Interface
- CTRL_W, default 8: control bits (WB_EN, MEM_R_EN, MEM_W_EN, S, B, …). Zeroed on every bubble.
- DATA_W, default 128: payload bits (PC, operand values, immediates, Dest, src ids).
- SKID, default 1: 1 = 2-entry skid buffer with registered ready; 0 = single register with combinational ready.
- CLEAR_DATA, default 1: 1 = payload also zeroed on flush/reset; 0 = payload retained and only control cleared.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  discard all held entries and present a bubble.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_ctrl  in  CTRL_W  upstream control.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  output entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  control to next stage; all-zero whenever out_valid=0.
- out_data  out  DATA_W  payload to next stage.
- occupancy  out  2  entries held (0..2; max 1 when SKID=0).
- flush_drops  out  16  saturating count of valid entries discarded by flush.

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Outputs come directly from the main register (M). The skid register (S) exists only when SKID=1.
- States (SKID=1): EMPTY (occ 0), ONE (M full), TWO (M and S full).
  - EMPTY: in_fire → ONE, M ← in.
  - ONE, in_fire & out_fire: stay in ONE, M ← in.
  - ONE, in_fire only: → TWO, S ← in.
  - ONE, out_fire only: → EMPTY, M ctrl ← 0.
  - TWO: in_ready=0. out_fire → ONE, M ← S, S ctrl ← 0.
- in_ready (SKID=1) = (state≠TWO) & ~flush & ~rst. It depends only on state and flush, never on out_ready.
- SKID=0: states EMPTY/ONE only. in_ready = (~out_valid | out_ready) & ~flush & ~rst.
- Flush has priority over every handshake event:
  - state → EMPTY; M and S ctrl ← 0; payload ← 0 if CLEAR_DATA.
  - in_fire is impossible during flush because in_ready=0.
  - flush_drops += occupancy (0, 1 or 2), saturating at 16'hFFFF.
- Ordering is FIFO: entries leave in acceptance order. An entry is never duplicated or lost except by flush.
- out_ctrl is zero whenever out_valid=0, so a downstream stage ignoring out_valid still sees a NOP.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, flush_drops=0, in_ready=0 while rst is high. in_ready=1 in the first cycle after rst deasserts.
- Reset mid-operation clears everything asynchronously, including held entries. flush_drops does not count entries cleared by reset.
- Latency: an entry accepted at edge N is visible on out_* after edge N, one cycle. A stalled entry holds its value indefinitely.
- Throughput: 1 entry/cycle when out_ready=1.
- SKID=1: at most one extra entry is accepted after out_ready drops. in_ready deasserts the cycle after TWO is entered.
- Flush asserted at edge N: out_valid=0 after N. New input is accepted at edge N+1 if flush is low.
- Flush and out_fire in the same cycle: the downstream transfer completes (the downstream stage samples it). The stage still empties, and that entry is not counted in flush_drops.

## Test plan
- Streaming: SKID=1, out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles → out_data 1,2,3,4 one cycle later, occupancy constant 1, in_ready stays 1.
- Back-pressure: in_valid=1 with data A,B,C; out_ready=0 from the cycle A appears → B captured in skid, occupancy=2, in_ready=0, C held upstream. Release out_ready → outputs A,B,C in order with no gaps.
- Flush in TWO: state with occupancy=2, ctrl=8'hFF, assert flush one cycle → out_valid=0, out_ctrl=0, out_data=0 (CLEAR_DATA=1), flush_drops=2. Next cycle in_ready=1.
- Flush with simultaneous out_fire in ONE → entry consumed once, occupancy=0, flush_drops unchanged.
- Async reset mid-stream: assert rst between edges with occupancy=2 → all outputs 0 immediately. After release, first accepted entry appears exactly one cycle later.
- SKID=0: out_ready toggling 1,0,1 with continuous input → in_ready follows (~out_valid | out_ready) combinationally, no entry lost or duplicated, occupancy never exceeds 1.
